// File: rtl/bit_extend_unit.sv
// bit_extend_unit: widens an IN_W-bit operand to IN_W*REP bits by
// zero-extend, sign-extend or per-bit replicate, through a 2-entry buffer.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     operand handshake (in_ready is register-derived)
//   in_data, in_mode      operand; mode 00 zero, 01 sign, 10 replicate, 11 reserved
//   out_valid/out_ready   result handshake, out_data is the oldest entry
//   mode_err              one-cycle pulse after accepting a mode-11 operand
//   txn_count             wrapping count of output handshakes
module bit_extend_unit #(
    parameter int IN_W  = 4,
    parameter int REP   = 8,
    parameter int CNT_W = 16,
    localparam int OUT_W = IN_W * REP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             mode_err,
    output logic [CNT_W-1:0] txn_count
);

    logic [OUT_W-1:0] mem [2];
    logic             wrPtr;
    logic             rdPtr;
    logic [1:0]       occ;
    logic [OUT_W-1:0] result;
    logic             accept;
    logic             pop;
    logic             isSign;
    logic             isRep;

    assign isSign = (in_mode == 2'b01);
    assign isRep  = (in_mode == 2'b10);

    // Reserved mode falls through to zero-extend.
    always_comb begin
        result = '0;
        unique case (1'b1)
            isSign: result = OUT_W'($signed(in_data));
            isRep: begin
                for (int i = 0; i < IN_W; i++) begin
                    result[i*REP +: REP] = {REP{in_data[i]}};
                end
            end
            default: result = OUT_W'(in_data);
        endcase
    end

    // Both flags come from the occupancy register only, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_data  = mem[rdPtr];

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wrPtr     <= 1'b0;
            rdPtr     <= 1'b0;
            occ       <= 2'd0;
            mode_err  <= 1'b0;
            txn_count <= '0;
        end else begin
            if (accept) begin
                mem[wrPtr] <= result;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr     <= ~rdPtr;
                txn_count <= txn_count + CNT_W'(1);
            end
            unique case ({accept, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            mode_err <= accept && (in_mode == 2'b11);
        end
    end

endmodule

// File: doc/bit_extend_unit.md
# bit_extend_unit

Parametrised, handshaked extension unit for the ALU datapath. It takes an IN_W-bit operand and widens it to OUT_W = IN_W*REP bits using one of three selectable modes: zero-extend, sign-extend, or per-bit replicate. Results pass through a 2-entry output buffer with valid/ready on both sides, so the upstream operand source and the downstream ALU stage can stall independently. A wrapping transaction counter and a mode-error flag support debug.

## Interface
- IN_W, 4, input operand width (>= 1)
- REP, 8, replication factor; OUT_W = IN_W*REP is derived, not overridable
- CNT_W, 16, width of completed-transaction counter
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand/mode present
- in_ready  output  1  unit can accept; registered, no combinational path from out_ready
- in_data  input  IN_W  operand
- in_mode  input  2  00 zero-extend, 01 sign-extend, 10 bit-replicate, 11 reserved
- out_valid  output  1  head result present
- out_ready  input  1  downstream accepts head
- out_data  output  OUT_W  head result
- mode_err  output  1  one-cycle pulse, registered, when an operand with mode 11 is accepted
- txn_count  output  CNT_W  count of output handshakes, wraps

## Operation
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- Result computed combinationally from in_data/in_mode at accept and written into the buffer. Buffer stores results only, not modes.
- Zero-extend: out = {(OUT_W-IN_W) zeros, in_data}.
- Sign-extend: out = {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
- Bit-replicate: out[i*REP +: REP] = {REP{in_data[i]}} for i = 0..IN_W-1.
- Mode 11: result as zero-extend; mode_err = 1 in the cycle after accept.
- REP = 1: all modes yield in_data. Mode 11 still flags.
- Buffer is a 2-entry FIFO with occupancy 0..2. in_ready = (occupancy < 2). out_valid = (occupancy > 0). out_data = oldest entry, stable while out_valid && !out_ready.
- Simultaneous accept and pop at occupancy 1: occupancy stays 1. The new result becomes head on the next cycle; order is preserved.
- At occupancy 2, in_ready = 0. A pop frees a slot, and in_ready rises the following cycle.
- At occupancy 0 no pop occurs; out_ready is ignored.
- txn_count increments by 1 per pop. It wraps from 2^CNT_W-1 to 0.
- in_data and in_mode are ignored when in_valid = 0. Upstream must hold in_valid, in_data and in_mode stable until accepted.

## Timing
- Reset values, applied immediately on rst = 1 with no clock needed:
  - occupancy = 0, so out_valid = 0 and in_ready = 1
  - out_data = 0, mode_err = 0, txn_count = 0
  - buffer contents cleared to 0
- Reset mid-operation discards all buffered results. No partial handshake completes.
- Latency: accept at edge k, then out_valid = 1 with the result after edge k (visible during cycle k+1) when the buffer is empty.
- Throughput is 1 result/cycle when out_ready is held high.
- mode_err asserts for exactly the cycle after the accepting edge.
- txn_count updates on the popping edge.

## Test plan
- Reset: assert rst asynchronously between edges. Required: out_valid = 0, in_ready = 1, txn_count = 0, mode_err = 0 immediately, before the next edge.
- Modes, defaults, out_ready = 1, in_data = 4'b1010:
  - mode 00 -> 32'h0000000A
  - mode 01 -> 32'hFFFFFFFA
  - mode 10 -> 32'hFF00FF00
  - each appears 1 cycle after accept; txn_count = 3 afterwards
- Positive sign-extend and REP = 1: in_data = 4'b0111, mode 01 -> 32'h00000007. With a second instance IN_W = 8, REP = 1, in_data = 8'hA5 in any mode -> 8'hA5.
- Backpressure: out_ready = 0, offer three operands 1, 2, 3 in mode 00.
  - in_ready falls after the second accept; third operand held
  - raise out_ready: outputs 1, 2, 3 in order, one per cycle after in_ready recovers
  - no loss or duplication
- Mode 11 with in_data = 4'hC -> out_data 32'h0000000C, mode_err high for exactly one cycle.
- Counter wrap and reset mid-flight:
  - CNT_W = 2: five pops -> txn_count sequence 1, 2, 3, 0, 1
  - rst with 2 entries buffered -> out_valid = 0 and no stale data after release
